// File: rtl/vx_mem_bridge_pkg.sv
// Shared memory-bridge widths and request/response payload types.
`ifndef VX_MEM_DATA_WIDTH
`define VX_MEM_DATA_WIDTH 512
`endif
`ifndef VX_MEM_ADDR_WIDTH
`define VX_MEM_ADDR_WIDTH 26
`endif
`ifndef VX_MEM_TAG_WIDTH
`define VX_MEM_TAG_WIDTH 56
`endif

package vx_mem_bridge_pkg;

    localparam int unsigned MEM_DATA_WIDTH   = `VX_MEM_DATA_WIDTH;
    localparam int unsigned MEM_ADDR_WIDTH   = `VX_MEM_ADDR_WIDTH;
    localparam int unsigned MEM_TAG_WIDTH    = `VX_MEM_TAG_WIDTH;
    localparam int unsigned MEM_BYTEEN_WIDTH = MEM_DATA_WIDTH / 8;

    typedef struct packed {
        logic                        rw;
        logic [MEM_BYTEEN_WIDTH-1:0] byteen;
        logic [MEM_ADDR_WIDTH-1:0]   addr;
        logic [MEM_DATA_WIDTH-1:0]   data;
        logic [MEM_TAG_WIDTH-1:0]    tag;
    } mem_req_t;

    typedef struct packed {
        logic [MEM_DATA_WIDTH-1:0] data;
        logic [MEM_TAG_WIDTH-1:0]  tag;
    } mem_rsp_t;

endpackage

// File: rtl/vx_mem_fifo.sv
// Power-of-two circular FIFO with valid/ready on both sides and registered
// full/empty flags; an entry written in cycle N is visible at the head in N+1.
module vx_mem_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full_q;
    logic             empty_q;
    logic             push;
    logic             pop;

    // Full blocks the write even when a pop happens in the same cycle.
    assign push      = in_valid && !full_q;
    assign pop       = out_ready && !empty_q;
    assign in_ready  = !full_q;
    assign out_valid = !empty_q;
    assign out_data  = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Storage carries no reset; occupancy is tracked by the flags above.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

endmodule

// File: rtl/vx_mem_reqrsp_buffer.sv
// Core-to-local-memory bridge: in-order request FIFO with read-credit
// throttling, and a 2-entry response skid buffer back to the core.
module vx_mem_reqrsp_buffer
    import vx_mem_bridge_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = MEM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH      = MEM_ADDR_WIDTH,
    parameter int unsigned TAG_WIDTH       = MEM_TAG_WIDTH,
    parameter int unsigned BYTEEN_WIDTH    = DATA_WIDTH / 8,
    parameter int unsigned REQ_DEPTH       = 4,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                                     clk,
    input  logic                                     reset,

    input  logic                                     core_req_valid,
    input  logic                                     core_req_rw,
    input  logic [BYTEEN_WIDTH-1:0]                  core_req_byteen,
    input  logic [ADDR_WIDTH-1:0]                    core_req_addr,
    input  logic [DATA_WIDTH-1:0]                    core_req_data,
    input  logic [TAG_WIDTH-1:0]                     core_req_tag,
    output logic                                     core_req_ready,

    output logic                                     mem_req_valid,
    output logic                                     mem_req_rw,
    output logic [BYTEEN_WIDTH-1:0]                  mem_req_byteen,
    output logic [ADDR_WIDTH-1:0]                    mem_req_addr,
    output logic [DATA_WIDTH-1:0]                    mem_req_data,
    output logic [TAG_WIDTH-1:0]                     mem_req_tag,
    input  logic                                     mem_req_ready,

    input  logic                                     mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]                    mem_rsp_data,
    input  logic [TAG_WIDTH-1:0]                     mem_rsp_tag,
    output logic                                     mem_rsp_ready,

    output logic                                     core_rsp_valid,
    output logic [DATA_WIDTH-1:0]                    core_rsp_data,
    output logic [TAG_WIDTH-1:0]                     core_rsp_tag,
    input  logic                                     core_rsp_ready,

    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding,
    output logic                                     busy,
    output logic                                     rsp_underflow
);

    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic                    rw;
        logic [BYTEEN_WIDTH-1:0] byteen;
        logic [ADDR_WIDTH-1:0]   addr;
        logic [DATA_WIDTH-1:0]   data;
        logic [TAG_WIDTH-1:0]    tag;
    } req_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [TAG_WIDTH-1:0]  tag;
    } rsp_t;

    localparam int unsigned REQ_W = $bits(req_t);
    localparam int unsigned RSP_W = $bits(rsp_t);

    req_t          req_in;
    req_t          req_head;
    rsp_t          rsp_in;
    rsp_t          rsp_head;
    logic          req_head_valid;
    logic          req_pop;
    logic          credit_ok;
    logic          rd_issue;
    logic          rsp_accept;
    logic          rsp_deliver;
    logic [OW-1:0] outstanding_q;
    logic          underflow_q;

    assign req_in = '{rw: core_req_rw, byteen: core_req_byteen, addr: core_req_addr,
                      data: core_req_data, tag: core_req_tag};

    vx_mem_fifo #(
        .DEPTH (REQ_DEPTH),
        .WIDTH (REQ_W)
    ) req_fifo (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (core_req_valid),
        .in_ready  (core_req_ready),
        .in_data   (req_in),
        .out_valid (req_head_valid),
        .out_ready (req_pop),
        .out_data  (req_head)
    );

    // Reads at the head wait for a credit; writes never do, but stay in order.
    assign credit_ok     = req_head.rw || (outstanding_q < OW'(MAX_OUTSTANDING));
    assign mem_req_valid = req_head_valid && credit_ok;
    assign req_pop       = mem_req_ready && credit_ok;
    assign rd_issue      = mem_req_valid && mem_req_ready && !req_head.rw;

    assign mem_req_rw     = req_head.rw;
    assign mem_req_byteen = req_head.byteen;
    assign mem_req_addr   = req_head.addr;
    assign mem_req_data   = req_head.data;
    assign mem_req_tag    = req_head.tag;

    assign rsp_in = '{data: mem_rsp_data, tag: mem_rsp_tag};

    vx_mem_fifo #(
        .DEPTH (2),
        .WIDTH (RSP_W)
    ) rsp_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (mem_rsp_valid),
        .in_ready  (mem_rsp_ready),
        .in_data   (rsp_in),
        .out_valid (core_rsp_valid),
        .out_ready (core_rsp_ready),
        .out_data  (rsp_head)
    );

    assign core_rsp_data = rsp_head.data;
    assign core_rsp_tag  = rsp_head.tag;
    assign rsp_accept    = mem_rsp_valid && mem_rsp_ready;
    assign rsp_deliver   = core_rsp_valid && core_rsp_ready;

    // Credits return on delivery to the core; an orphan response cannot drive it below zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding_q <= '0;
            underflow_q   <= 1'b0;
        end else begin
            if (rd_issue && !rsp_deliver) begin
                outstanding_q <= outstanding_q + OW'(1);
            end else if (!rd_issue && rsp_deliver && (outstanding_q != '0)) begin
                outstanding_q <= outstanding_q - OW'(1);
            end
            if (rsp_accept && (outstanding_q == '0)) underflow_q <= 1'b1;
        end
    end

    assign outstanding   = outstanding_q;
    assign rsp_underflow = underflow_q;
    assign busy          = req_head_valid || core_rsp_valid || (outstanding_q != '0);

endmodule

// File: tb/tb_vx_mem_reqrsp_buffer.sv
// Directed self-checking bench for vx_mem_reqrsp_buffer at default widths.
module tb_vx_mem_reqrsp_buffer;

    logic         clk = 1'b0;
    logic         reset;
    logic         core_req_valid;
    logic         core_req_rw;
    logic [63:0]  core_req_byteen;
    logic [25:0]  core_req_addr;
    logic [511:0] core_req_data;
    logic [55:0]  core_req_tag;
    logic         core_req_ready;
    logic         mem_req_valid;
    logic         mem_req_rw;
    logic [63:0]  mem_req_byteen;
    logic [25:0]  mem_req_addr;
    logic [511:0] mem_req_data;
    logic [55:0]  mem_req_tag;
    logic         mem_req_ready;
    logic         mem_rsp_valid;
    logic [511:0] mem_rsp_data;
    logic [55:0]  mem_rsp_tag;
    logic         mem_rsp_ready;
    logic         core_rsp_valid;
    logic [511:0] core_rsp_data;
    logic [55:0]  core_rsp_tag;
    logic         core_rsp_ready;
    logic [3:0]   outstanding;
    logic         busy;
    logic         rsp_underflow;

    int total = 0;
    int bad   = 0;

    vx_mem_reqrsp_buffer dut (
        .clk             (clk),
        .reset           (reset),
        .core_req_valid  (core_req_valid),
        .core_req_rw     (core_req_rw),
        .core_req_byteen (core_req_byteen),
        .core_req_addr   (core_req_addr),
        .core_req_data   (core_req_data),
        .core_req_tag    (core_req_tag),
        .core_req_ready  (core_req_ready),
        .mem_req_valid   (mem_req_valid),
        .mem_req_rw      (mem_req_rw),
        .mem_req_byteen  (mem_req_byteen),
        .mem_req_addr    (mem_req_addr),
        .mem_req_data    (mem_req_data),
        .mem_req_tag     (mem_req_tag),
        .mem_req_ready   (mem_req_ready),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_data    (mem_rsp_data),
        .mem_rsp_tag     (mem_rsp_tag),
        .mem_rsp_ready   (mem_rsp_ready),
        .core_rsp_valid  (core_rsp_valid),
        .core_rsp_data   (core_rsp_data),
        .core_rsp_tag    (core_rsp_tag),
        .core_rsp_ready  (core_rsp_ready),
        .outstanding     (outstanding),
        .busy            (busy),
        .rsp_underflow   (rsp_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic set_req(input logic v, input logic rw, input logic [25:0] a, input logic [55:0] t);
        core_req_valid  = v;
        core_req_rw     = rw;
        core_req_addr   = a;
        core_req_tag    = t;
        core_req_byteen = '1;
        core_req_data   = 512'(t) + 512'h1000;
    endtask

    task automatic set_rsp(input logic v, input logic [511:0] d, input logic [55:0] t);
        mem_rsp_valid = v;
        mem_rsp_data  = d;
        mem_rsp_tag   = t;
    endtask

    initial begin
        set_req(1'b0, 1'b0, '0, '0);
        set_rsp(1'b0, '0, '0);
        mem_req_ready  = 1'b1;
        core_rsp_ready = 1'b1;
        do_reset();

        // Reset state
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_core_rsp_valid", core_rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_core_req_ready", core_req_ready, 1);
        chk("rst_mem_rsp_ready", mem_rsp_ready, 1);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_underflow", rsp_underflow, 0);

        // Single read round trip
        set_req(1'b1, 1'b0, 26'h10, 56'h5);
        chk("a_no_bypass", mem_req_valid, 0);
        step();
        set_req(1'b0, 1'b0, '0, '0);
        chk("a_mem_req_valid", mem_req_valid, 1);
        chk("a_mem_req_addr", mem_req_addr, 'h10);
        chk("a_mem_req_tag", mem_req_tag, 'h5);
        chk("a_mem_req_rw", mem_req_rw, 0);
        chk("a_busy_queued", busy, 1);
        step();
        chk("a_outstanding_1", outstanding, 1);
        chk("a_mem_req_idle", mem_req_valid, 0);
        set_rsp(1'b1, 512'hAB, 56'h5);
        step();
        set_rsp(1'b0, '0, '0);
        chk("a_core_rsp_valid", core_rsp_valid, 1);
        chk("a_core_rsp_data", core_rsp_data, 'hAB);
        chk("a_core_rsp_tag", core_rsp_tag, 'h5);
        step();
        chk("a_outstanding_0", outstanding, 0);
        chk("a_busy_0", busy, 0);
        chk("a_core_rsp_done", core_rsp_valid, 0);
        chk("a_underflow", rsp_underflow, 0);

        // Back-pressure fills the request FIFO
        mem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_req(1'b1, 1'b0, 26'(i), 56'h21 + 56'(i));
            chk($sformatf("b_req_ready_%0d", i), core_req_ready, (i < 4) ? 1 : 0);
            step();
        end
        set_req(1'b0, 1'b0, '0, '0);
        chk("b_head_tag", mem_req_tag, 'h21);
        step();
        chk("b_head_stable", mem_req_tag, 'h21);
        chk("b_head_valid", mem_req_valid, 1);
        mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b_issue_valid_%0d", i), mem_req_valid, 1);
            chk($sformatf("b_issue_tag_%0d", i), mem_req_tag, 56'h21 + 56'(i));
            step();
        end
        chk("b_drained", mem_req_valid, 0);
        chk("b_outstanding_4", outstanding, 4);
        do_reset();

        // Credit limit stalls the ninth read and the write queued behind it
        for (int i = 0; i < 9; i++) begin
            set_req(1'b1, 1'b0, 26'(i), 56'h30 + 56'(i));
            step();
        end
        set_req(1'b1, 1'b1, 26'h40, 56'h40);
        core_req_data = 512'hDEAD;
        step();
        set_req(1'b0, 1'b0, '0, '0);
        chk("c_outstanding_8", outstanding, 8);
        chk("c_stalled", mem_req_valid, 0);
        chk("c_head_tag", mem_req_tag, 'h38);
        step();
        chk("c_still_stalled", mem_req_valid, 0);
        set_rsp(1'b1, 512'h77, 56'h30);
        step();
        set_rsp(1'b0, '0, '0);
        chk("c_rsp_fwd", core_rsp_valid, 1);
        chk("c_outstanding_held", outstanding, 8);
        chk("c_stall_until_deliver", mem_req_valid, 0);
        step();
        chk("c_outstanding_7", outstanding, 7);
        chk("c_ninth_valid", mem_req_valid, 1);
        chk("c_ninth_tag", mem_req_tag, 'h38);
        step();
        chk("c_write_valid", mem_req_valid, 1);
        chk("c_write_rw", mem_req_rw, 1);
        chk("c_write_tag", mem_req_tag, 'h40);
        chk("c_write_data", mem_req_data, 'hDEAD);
        chk("c_write_byteen", mem_req_byteen, {64{1'b1}});
        step();
        chk("c_write_no_credit", outstanding, 8);
        chk("c_all_issued", mem_req_valid, 0);
        do_reset();

        // Response skid buffer under core back-pressure
        core_rsp_ready = 1'b0;
        set_rsp(1'b1, 512'h100, 56'h1);
        chk("d_ready_0", mem_rsp_ready, 1);
        step();
        set_rsp(1'b1, 512'h101, 56'h2);
        chk("d_ready_1", mem_rsp_ready, 1);
        step();
        set_rsp(1'b1, 512'h102, 56'h3);
        chk("d_full", mem_rsp_ready, 0);
        step();
        chk("d_full_held", mem_rsp_ready, 0);
        chk("d_head_data", core_rsp_data, 'h100);
        chk("d_head_tag", core_rsp_tag, 'h1);
        core_rsp_ready = 1'b1;
        step();
        chk("d_second_data", core_rsp_data, 'h101);
        chk("d_second_tag", core_rsp_tag, 'h2);
        chk("d_ready_again", mem_rsp_ready, 1);
        step();
        set_rsp(1'b0, '0, '0);
        chk("d_third_valid", core_rsp_valid, 1);
        chk("d_third_data", core_rsp_data, 'h102);
        chk("d_third_tag", core_rsp_tag, 'h3);
        step();
        chk("d_empty", core_rsp_valid, 0);
        do_reset();

        // Orphan response sets the sticky underflow flag
        set_rsp(1'b1, 512'h55, 56'h7);
        step();
        set_rsp(1'b0, '0, '0);
        chk("e_underflow_set", rsp_underflow, 1);
        chk("e_forwarded", core_rsp_valid, 1);
        chk("e_fwd_tag", core_rsp_tag, 'h7);
        chk("e_outstanding_0", outstanding, 0);
        step();
        step();
        chk("e_underflow_sticky", rsp_underflow, 1);
        chk("e_no_wrap", outstanding, 0);
        do_reset();
        chk("e_underflow_cleared", rsp_underflow, 0);

        // Reset discards queued requests and buffered responses
        mem_req_ready  = 1'b0;
        core_rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, 1'b0, 26'(i), 56'h60 + 56'(i));
            if (i < 2) set_rsp(1'b1, 512'(i), 56'h70 + 56'(i));
            else       set_rsp(1'b0, '0, '0);
            step();
        end
        set_req(1'b0, 1'b0, '0, '0);
        chk("f_pre_mem_req_valid", mem_req_valid, 1);
        chk("f_pre_core_rsp_valid", core_rsp_valid, 1);
        chk("f_pre_busy", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("f_mem_req_valid", mem_req_valid, 0);
        chk("f_core_rsp_valid", core_rsp_valid, 0);
        chk("f_busy", busy, 0);
        chk("f_outstanding", outstanding, 0);
        chk("f_core_req_ready", core_req_ready, 1);
        chk("f_mem_rsp_ready", mem_rsp_ready, 1);
        chk("f_underflow", rsp_underflow, 0);
        mem_req_ready = 1'b1;
        step();
        chk("f_no_handoff", mem_req_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
